// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - SM83 register, pair, IDU and flag encodings shared with the decoder
package cpu_pkg;

  localparam logic [2:0] R_B = 3'd0;
  localparam logic [2:0] R_C = 3'd1;
  localparam logic [2:0] R_D = 3'd2;
  localparam logic [2:0] R_E = 3'd3;
  localparam logic [2:0] R_H = 3'd4;
  localparam logic [2:0] R_L = 3'd5;
  localparam logic [2:0] R_F = 3'd6;
  localparam logic [2:0] R_A = 3'd7;

  localparam logic [1:0] RP_BC = 2'd0;
  localparam logic [1:0] RP_DE = 2'd1;
  localparam logic [1:0] RP_HL = 2'd2;
  localparam logic [1:0] RP_SP = 2'd3;

  localparam logic [2:0] IDU_BC = 3'd0;
  localparam logic [2:0] IDU_DE = 3'd1;
  localparam logic [2:0] IDU_HL = 3'd2;
  localparam logic [2:0] IDU_SP = 3'd3;
  localparam logic [2:0] IDU_PC = 3'd4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [15:0] sp;
    logic [15:0] pc;
  } idu_src_t;

  // F has no storage in its low nibble; every path through F goes via this.
  function automatic logic [7:0] f_clean(input logic [7:0] v);
    return {v[7:4], 4'h0};
  endfunction

endpackage

// File: rtl/cpu_regfile_if.sv
// rtl/cpu_regfile_if.sv - register file access bus between sequencer/ALU and cpu_regfile
interface cpu_regfile_if #(
  parameter int NUM_RD8 = 2
);
  logic [3*NUM_RD8-1:0] rd8_sel;
  logic [8*NUM_RD8-1:0] rd8_data;
  logic [1:0]           rd16_sel;
  logic                 rd16_af;
  logic [15:0]          rd16_data;
  logic                 wr8_en;
  logic [2:0]           wr8_sel;
  logic [7:0]           wr8_data;
  logic                 wr16_en;
  logic [1:0]           wr16_sel;
  logic                 wr16_af;
  logic [15:0]          wr16_data;
  logic                 idu_en;
  logic [2:0]           idu_sel;
  logic                 idu_dec;
  logic [3:0]           flag_we;
  logic [3:0]           flag_in;
  logic                 pc_we;
  logic [15:0]          pc_in;
  logic [15:0]          pc;
  logic [15:0]          sp;
  logic [3:0]           flags;

  modport master (
    output rd8_sel, rd16_sel, rd16_af,
    output wr8_en, wr8_sel, wr8_data,
    output wr16_en, wr16_sel, wr16_af, wr16_data,
    output idu_en, idu_sel, idu_dec,
    output flag_we, flag_in, pc_we, pc_in,
    input  rd8_data, rd16_data, pc, sp, flags
  );

  modport slave (
    input  rd8_sel, rd16_sel, rd16_af,
    input  wr8_en, wr8_sel, wr8_data,
    input  wr16_en, wr16_sel, wr16_af, wr16_data,
    input  idu_en, idu_sel, idu_dec,
    input  flag_we, flag_in, pc_we, pc_in,
    output rd8_data, rd16_data, pc, sp, flags
  );
endinterface

// File: rtl/cpu_idu.sv
// rtl/cpu_idu.sv - 16-bit increment/decrement unit with target mux
module cpu_idu
  import cpu_pkg::*;
(
  input  idu_src_t    src,
  input  logic [2:0]  sel,
  input  logic        dec,
  output logic [15:0] result,
  output logic        valid
);

  logic [15:0] operand;

  always_comb begin
    operand = 16'h0000;
    valid   = 1'b1;
    case (sel)
      IDU_BC:  operand = src.bc;
      IDU_DE:  operand = src.de;
      IDU_HL:  operand = src.hl;
      IDU_SP:  operand = src.sp;
      IDU_PC:  operand = src.pc;
      default: valid   = 1'b0;
    endcase
  end

  assign result = dec ? operand - 16'd1 : operand + 16'd1;

endmodule

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - SM83 register file with pair access, IDU stepping and masked flag updates
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int          NUM_RD8  = 2,
  parameter logic [15:0] RESET_PC = 16'h0100,
  parameter logic [15:0] RESET_SP = 16'hFFFE,
  parameter logic [15:0] RESET_AF = 16'h01B0,
  parameter logic [15:0] RESET_BC = 16'h0013,
  parameter logic [15:0] RESET_DE = 16'h00D8,
  parameter logic [15:0] RESET_HL = 16'h014D
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_regfile_if.slave  bus
);

  // Byte registers indexed directly by the R8 encoding.
  logic [7:0]  r     [8];
  logic [7:0]  r_nxt [8];
  logic [15:0] sp_reg, sp_nxt;
  logic [15:0] pc_reg, pc_nxt;

  idu_src_t    idu_src;
  logic [15:0] idu_result;
  logic        idu_valid;

  assign idu_src.bc = {r[R_B], r[R_C]};
  assign idu_src.de = {r[R_D], r[R_E]};
  assign idu_src.hl = {r[R_H], r[R_L]};
  assign idu_src.sp = sp_reg;
  assign idu_src.pc = pc_reg;

  cpu_idu u_idu (
    .src    (idu_src),
    .sel    (bus.idu_sel),
    .dec    (bus.idu_dec),
    .result (idu_result),
    .valid  (idu_valid)
  );

  // Later paths overwrite earlier ones: wr8 < wr16 < idu < pc_we < flag_we.
  always_comb begin
    r_nxt  = r;
    sp_nxt = sp_reg;
    pc_nxt = pc_reg;

    if (bus.wr8_en) begin
      r_nxt[bus.wr8_sel] = bus.wr8_data;
    end

    if (bus.wr16_en) begin
      case (bus.wr16_sel)
        RP_BC: begin r_nxt[R_B] = bus.wr16_data[15:8]; r_nxt[R_C] = bus.wr16_data[7:0]; end
        RP_DE: begin r_nxt[R_D] = bus.wr16_data[15:8]; r_nxt[R_E] = bus.wr16_data[7:0]; end
        RP_HL: begin r_nxt[R_H] = bus.wr16_data[15:8]; r_nxt[R_L] = bus.wr16_data[7:0]; end
        default: begin
          if (bus.wr16_af) begin
            r_nxt[R_A] = bus.wr16_data[15:8];
            r_nxt[R_F] = bus.wr16_data[7:0];
          end else begin
            sp_nxt = bus.wr16_data;
          end
        end
      endcase
    end

    if (bus.idu_en && idu_valid) begin
      case (bus.idu_sel)
        IDU_BC:  begin r_nxt[R_B] = idu_result[15:8]; r_nxt[R_C] = idu_result[7:0]; end
        IDU_DE:  begin r_nxt[R_D] = idu_result[15:8]; r_nxt[R_E] = idu_result[7:0]; end
        IDU_HL:  begin r_nxt[R_H] = idu_result[15:8]; r_nxt[R_L] = idu_result[7:0]; end
        IDU_SP:  sp_nxt = idu_result;
        default: pc_nxt = idu_result;
      endcase
    end

    if (bus.pc_we) begin
      pc_nxt = bus.pc_in;
    end

    for (int i = FLAG_C; i <= FLAG_Z; i++) begin
      if (bus.flag_we[i]) begin
        r_nxt[R_F][4+i] = bus.flag_in[i];
      end
    end
    r_nxt[R_F] = f_clean(r_nxt[R_F]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r[R_A] <= RESET_AF[15:8];
      r[R_F] <= f_clean(RESET_AF[7:0]);
      r[R_B] <= RESET_BC[15:8];
      r[R_C] <= RESET_BC[7:0];
      r[R_D] <= RESET_DE[15:8];
      r[R_E] <= RESET_DE[7:0];
      r[R_H] <= RESET_HL[15:8];
      r[R_L] <= RESET_HL[7:0];
      sp_reg <= RESET_SP;
      pc_reg <= RESET_PC;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r[i] <= r_nxt[i];
      end
      sp_reg <= sp_nxt;
      pc_reg <= pc_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD8; g++) begin : g_rd8
    assign bus.rd8_data[8*g +: 8] = r[bus.rd8_sel[3*g +: 3]];
  end

  always_comb begin
    bus.rd16_data = 16'h0000;
    case (bus.rd16_sel)
      RP_BC:   bus.rd16_data = {r[R_B], r[R_C]};
      RP_DE:   bus.rd16_data = {r[R_D], r[R_E]};
      RP_HL:   bus.rd16_data = {r[R_H], r[R_L]};
      default: bus.rd16_data = bus.rd16_af ? {r[R_A], r[R_F]} : sp_reg;
    endcase
  end

  assign bus.pc    = pc_reg;
  assign bus.sp    = sp_reg;
  assign bus.flags = r[R_F][7:4];

endmodule
